// File: rtl/enc_serial_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg : shared definitions for the serial set-bit encoder.
//   enc_state_e    : encoder control state (ENC_IDLE / ENC_BUSY)
//   ENC_N_DEFAULT  : default request-vector width
// Optional build macro: ENC_SERIAL_MSB_FIRST_EN (see enc_prio / enc_serial).
// ---------------------------------------------------------------------------
package enc_pkg;

    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_BUSY = 1'b1
    } enc_state_e;

    localparam int unsigned ENC_N_DEFAULT = 4;

endpackage : enc_pkg

// File: rtl/enc_serial_prio.sv
// ---------------------------------------------------------------------------
// enc_prio : combinational priority pick over an N-bit vector.
//   vec_i    [N-1:0] : candidate vector
//   idx_o    [W-1:0] : index of the selected set bit (0 when vec_i == 0)
//   mask_o   [N-1:0] : one-hot mask of the selected bit (0 when vec_i == 0)
//   single_o         : vec_i has exactly one bit set
// Build macro ENC_SERIAL_MSB_FIRST_EN: defined -> highest set bit selected,
// undefined -> lowest set bit selected.
// ---------------------------------------------------------------------------
module enc_prio
    import enc_pkg::*;
#(
    parameter int unsigned N = ENC_N_DEFAULT,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic [N-1:0] mask_o,
    output logic         single_o
);

    // Scan so that the preferred bit is visited last; the last hit wins.
    always_comb begin
        idx_o  = '0;
        mask_o = '0;
`ifdef ENC_SERIAL_MSB_FIRST_EN
        for (int unsigned i = 0; i < N; i++) begin
            if (vec_i[i]) begin
                idx_o     = W'(i);
                mask_o    = '0;
                mask_o[i] = 1'b1;
            end
        end
`else
        for (int unsigned j = 0; j < N; j++) begin
            if (vec_i[N-1-j]) begin
                idx_o         = W'(N-1-j);
                mask_o        = '0;
                mask_o[N-1-j] = 1'b1;
            end
        end
`endif
    end

    // Clearing the lowest set bit leaves zero only for a power of two.
    assign single_o = (vec_i != '0) && ((vec_i & (vec_i - N'(1))) == '0);

endmodule : enc_prio

// File: rtl/enc_serial.sv
// ---------------------------------------------------------------------------
// enc_serial : sequential encoder. Accepts an N-bit request vector and emits
// the index of every set bit, one per accepted output beat, flagging the
// final index with o_last.
//   i_clk            : clock, rising edge
//   i_rst            : asynchronous active-high reset
//   i_in   [N-1:0]   : request vector, sampled on i_valid && o_ready
//   i_valid          : i_in valid
//   o_ready          : block can accept a new vector (IDLE)
//   o_out  [W-1:0]   : index of the current set bit
//   o_valid          : o_out / o_last valid (BUSY)
//   i_ready          : consumer accepts the current beat
//   o_last           : current beat is the final set bit of the vector
// Build macro ENC_SERIAL_MSB_FIRST_EN: defined -> descending index order,
// o_last on the lowest set bit; undefined -> ascending order.
// ---------------------------------------------------------------------------
module enc_serial
    import enc_pkg::*;
#(
    parameter  int unsigned N = ENC_N_DEFAULT,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_in,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_out,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_last
);

    enc_state_e   state_q, state_d;
    logic [N-1:0] pend_q,  pend_d;

    logic [W-1:0] sel_idx;
    logic [N-1:0] sel_mask;
    logic         sel_single;

    enc_prio #(
        .N (N),
        .W (W)
    ) u_prio (
        .vec_i    (pend_q),
        .idx_o    (sel_idx),
        .mask_o   (sel_mask),
        .single_o (sel_single)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ENC_IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        case (state_q)
            ENC_IDLE: begin
                // A zero vector is accepted and dropped without a beat.
                if (i_valid && (i_in != '0)) begin
                    pend_d  = i_in;
                    state_d = ENC_BUSY;
                end
            end
            ENC_BUSY: begin
                if (i_ready) begin
                    pend_d = pend_q & ~sel_mask;
                    if (sel_single) begin
                        state_d = ENC_IDLE;
                    end
                end
            end
            default: begin
                state_d = ENC_IDLE;
                pend_d  = '0;
            end
        endcase
    end

    // pend is zero whenever IDLE, so o_out/o_last read 0 there.
    assign o_ready = (state_q == ENC_IDLE);
    assign o_valid = (state_q == ENC_BUSY);
    assign o_out   = sel_idx;
    assign o_last  = sel_single;

endmodule : enc_serial

// File: tb/tb_enc_serial.sv
module tb_enc_serial;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic         i_clk;
    logic         i_rst;
    logic [N-1:0] i_in;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] o_out;
    logic         o_valid;
    logic         i_ready;
    logic         o_last;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_q[$];

    enc_serial #(.N(N)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_in    (i_in),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_out   (o_out),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_last  (o_last)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Reference: list of set-bit indices in emission order.
    task automatic build_exp(input logic [N-1:0] v);
        exp_q.delete();
        for (int i = 0; i < int'(N); i++) begin
            if (v[i]) begin
`ifdef ENC_SERIAL_MSB_FIRST_EN
                exp_q.push_front(i);
`else
                exp_q.push_back(i);
`endif
            end
        end
    endtask

    function automatic logic [N-1:0] dec2_behavior(input logic [W-1:0] idx, input logic en);
        return en ? (N'(1) << idx) : '0;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
    endtask

    // Presents v for one cycle while IDLE, then scrambles i_in to show it is ignored.
    task automatic accept(input logic [N-1:0] v);
        check("acc_ready", 32'(o_ready), 32'd1);
        i_in    = v;
        i_valid = 1'b1;
        tick();
        build_exp(v);
        i_valid = ($urandom % 2) == 1;
        i_in    = N'($urandom);
    endtask

    task automatic drain(input bit rand_ready, output logic [N-1:0] recon);
        int cyc;
        recon = '0;
        cyc   = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            i_ready = rand_ready ? ($urandom % 2 == 1) : 1'b1;
            check("beat_valid", 32'(o_valid), 32'd1);
            check("beat_out",   32'(o_out),   32'(exp_q[0]));
            check("beat_last",  32'(o_last),  32'(exp_q.size() == 1));
            check("beat_ready", 32'(o_ready), 32'd0);
            if (i_ready) begin
                recon = recon | dec2_behavior(o_out, 1'b1);
                void'(exp_q.pop_front());
            end
            tick();
            cyc++;
        end
        check("drain_budget", 32'(exp_q.size()), 32'd0);
        i_ready = 1'b0;
        i_valid = 1'b0;
        check_idle("post");
    endtask

    logic [N-1:0] recon;
    logic [N-1:0] v;

    initial begin
        i_rst   = 1'b0;
        i_in    = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;

        // Asynchronous reset mid-cycle.
        #3 i_rst = 1'b1;
        #1;
        check_idle("rst");
        check("rst_out",  32'(o_out),  32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        tick();
        i_rst = 1'b0;
        tick();
        check_idle("rst_rel");

        // Multi-bit vector, consumer always ready.
        i_ready = 1'b1;
        accept(4'b1011);
        i_valid = 1'b0;
        drain(1'b0, recon);
        check("vec1011", 32'(recon), 32'(4'b1011));

        // Stall: hold i_ready low for three cycles.
        accept(4'b0110);
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_valid", 32'(o_valid), 32'd1);
            check("stall_out",   32'(o_out),   32'(exp_q[0]));
            check("stall_last",  32'(o_last),  32'd0);
            tick();
        end
        drain(1'b0, recon);
        check("vec0110", 32'(recon), 32'(4'b0110));

        // Zero vector is dropped; then a single-bit vector.
        i_in    = '0;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check_idle("zero1");
        tick();
        check_idle("zero2");
        accept(4'b1000);
        i_valid = 1'b0;
        check("single_out",  32'(o_out),  32'd3);
        check("single_last", 32'(o_last), 32'd1);
        drain(1'b0, recon);

        // Reset during BUSY after two beats.
        accept(4'b1111);
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        tick();
        check("pre_rst_valid", 32'(o_valid), 32'd1);
        #2 i_rst = 1'b1;
        #1;
        check_idle("midrst");
        check("midrst_out", 32'(o_out), 32'd0);
        tick();
        i_rst = 1'b0;
        tick();
        check_idle("midrst_rel");
        accept(4'b0100);
        i_valid = 1'b0;
        check("after_rst_out", 32'(o_out), 32'd2);
        drain(1'b0, recon);
        check("vec0100", 32'(recon), 32'(4'b0100));

        // Randomised cross-check via decoder reconstruction.
        for (int r = 0; r < 20; r++) begin
            v = N'($urandom);
            if ($urandom % 4 == 0) begin
                i_in    = v;
                i_valid = 1'b0;
                tick();
                check_idle("rnd_novalid");
            end else if (v == '0) begin
                i_in    = v;
                i_valid = 1'b1;
                tick();
                i_valid = 1'b0;
                check_idle("rnd_zero");
            end else begin
                accept(v);
                drain(1'b1, recon);
                check("rnd_recon", 32'(recon), 32'(v));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_enc_serial
